// File: rtl/sr_frame_buf.sv
// Double-buffered block store between the sign-reduction compressor and the
// bit-plane packer. Each completed block is replayed as one header beat
// (carrying the fail flag) followed by WORDS packed data beats.
module sr_frame_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_valid,
    input  logic              s_flag,
    input  logic              s_valid,
    output logic              ready_o,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_hdr,
    output logic              m_last,
    input  logic              m_ready,
    output logic              err_o
);
    localparam int unsigned      IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {BkFree, BkFill, BkFull, BkDrain} bank_e;
    typedef enum logic [1:0] {StIdle, StHdr, StData} out_e;

    bank_e             bank_q [2];
    bank_e             bank_d [2];
    logic [DATA_W-1:0] mem_q  [2][WORDS];
    logic [DATA_W-1:0] mem_d  [2][WORDS];
    logic              flag_q [2];
    logic              flag_d [2];
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    out_e              st_q, st_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_hdr_q, m_hdr_d;
    logic              m_last_q, m_last_d;
    logic              err_q, err_d;

    logic              wr_open;
    logic              d_take;
    logic              accept;
    logic              hdr_taken;
    logic              last_taken;
    logic [CNT_W-1:0]  rcnt_inc;
    logic [CNT_W-1:0]  wcnt_final;

    // Write bank still collecting; registered state only, giving a one-cycle skid.
    assign wr_open    = (bank_q[wbank_q] == BkFree) || (bank_q[wbank_q] == BkFill);
    assign d_take     = d_valid && wr_open && (wcnt_q < WORDS_C);
    assign wcnt_final = d_take ? (wcnt_q + ONE_C) : wcnt_q;
    assign accept     = m_valid_q && m_ready;
    assign rcnt_inc   = rcnt_q + ONE_C;

    assign ready_o = wr_open;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_hdr   = m_hdr_q;
    assign m_last  = m_last_q;
    assign err_o   = err_q;

    // Bank store: write-side fill/close plus read-side drain/release.
    always_comb begin
        bank_d  = bank_q;
        mem_d   = mem_q;
        flag_d  = flag_q;
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;

        if (d_take) begin
            mem_d[wbank_q][wcnt_q[IDX_W-1:0]] = d_data;
            wcnt_d          = wcnt_final;
            bank_d[wbank_q] = BkFill;
        end else if (d_valid) begin
            err_d = 1'b1;
        end

        // Same-cycle word is already counted in wcnt_final.
        if (s_valid) begin
            if (wr_open) begin
                flag_d[wbank_q] = s_flag;
                bank_d[wbank_q] = BkFull;
                if (wcnt_final != WORDS_C) begin
                    err_d = 1'b1;
                end
                wbank_d = ~wbank_q;
                wcnt_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (hdr_taken) begin
            bank_d[rbank_q] = BkDrain;
        end

        // Zero on release so a short block reads back zeros in unwritten slots.
        if (last_taken) begin
            bank_d[rbank_q] = BkFree;
            flag_d[rbank_q] = 1'b0;
            for (int unsigned w = 0; w < WORDS; w++) begin
                mem_d[rbank_q][w] = '0;
            end
        end
    end

    // Output FSM: next state and next registered beat.
    always_comb begin
        st_d       = st_q;
        rbank_d    = rbank_q;
        rcnt_d     = rcnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_hdr_d    = m_hdr_q;
        m_last_d   = m_last_q;
        hdr_taken  = 1'b0;
        last_taken = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (bank_q[rbank_q] == BkFull) begin
                    st_d      = StHdr;
                    m_valid_d = 1'b1;
                    m_hdr_d   = 1'b1;
                    m_last_d  = 1'b0;
                    m_data_d  = {{(DATA_W-1){1'b0}}, flag_q[rbank_q]};
                end
            end
            StHdr: begin
                if (accept) begin
                    hdr_taken = 1'b1;
                    st_d      = StData;
                    rcnt_d    = '0;
                    m_hdr_d   = 1'b0;
                    m_data_d  = mem_q[rbank_q][0];
                    m_last_d  = (WORDS == 1);
                end
            end
            StData: begin
                if (accept) begin
                    if (rcnt_q == LAST_C) begin
                        last_taken = 1'b1;
                        st_d       = StIdle;
                        rbank_d    = ~rbank_q;
                        m_valid_d  = 1'b0;
                        m_last_d   = 1'b0;
                        m_data_d   = '0;
                    end else begin
                        rcnt_d   = rcnt_inc;
                        m_data_d = mem_q[rbank_q][rcnt_inc[IDX_W-1:0]];
                        m_last_d = (rcnt_inc == LAST_C);
                    end
                end
            end
            default: begin
                st_d      = StIdle;
                m_valid_d = 1'b0;
                m_hdr_d   = 1'b0;
                m_last_d  = 1'b0;
                m_data_d  = '0;
            end
        endcase
    end

    // State registers; reset discards both banks and any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                bank_q[b] <= BkFree;
                flag_q[b] <= 1'b0;
                for (int unsigned w = 0; w < WORDS; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            st_q      <= StIdle;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_hdr_q   <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            mem_q     <= mem_d;
            flag_q    <= flag_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            st_q      <= st_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_hdr_q   <= m_hdr_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_sr_frame_buf.sv
// Bench for sr_frame_buf: frame-level scoreboard checked every cycle, plus
// directed checks on latency, backpressure, bank turnover, errors and reset.
module tb_sr_frame_buf;
    localparam int DATA_W = 64;
    localparam int WORDS  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] d_data;
    logic              d_valid;
    logic              s_flag;
    logic              s_valid;
    logic              ready_o;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_hdr;
    logic              m_last;
    logic              m_ready;
    logic              err_o;

    always #5 clk = ~clk;

    sr_frame_buf #(
        .DATA_W(DATA_W),
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_data (d_data),
        .d_valid(d_valid),
        .s_flag (s_flag),
        .s_valid(s_valid),
        .ready_o(ready_o),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_hdr  (m_hdr),
        .m_last (m_last),
        .m_ready(m_ready),
        .err_o  (err_o)
    );

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    // Model: expected beats as {hdr, last, data}; words of the block being collected;
    // number of banks holding a closed frame; sticky error.
    logic [65:0] exp_q[$];
    logic [63:0] cur_q[$];
    int          pend  = 0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k of a block is 0x11*k, one word every other cycle, then the close strobe.
    task automatic send_block(input int n, input logic flag);
        for (int k = 1; k <= n; k++) begin
            d_valid = 1'b1;
            d_data  = 64'h11 * 64'(k);
            tick();
            d_valid = 1'b0;
            d_data  = '0;
            tick();
        end
        s_valid = 1'b1;
        s_flag  = flag;
        tick();
        s_valid = 1'b0;
        s_flag  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(name, 66'(exp_q.size()), 66'd0);
        tick();
        tick();
    endtask

    task automatic wait_last();
        for (int i = 0; i < 100 && !(m_valid && m_last); i++) tick();
    endtask

    // Compare outputs against the model, then advance it with this cycle's inputs.
    always @(negedge clk) begin
        logic [65:0] b;
        logic        rdy;
        if (!rst_n) begin
            exp_q.delete();
            cur_q.delete();
            pend  = 0;
            m_err = 1'b0;
        end else begin
            rdy = (pend < 2);
            chk("ready_o", 66'(ready_o), 66'(rdy));
            chk("err_o", 66'(err_o), 66'(m_err));
            if (exp_q.size() == 0) begin
                chk("idle m_valid", 66'(m_valid), 66'd0);
            end else if (m_valid) begin
                chk("beat {hdr,last,data}", {m_hdr, m_last, m_data}, exp_q[0]);
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                beats++;
                if (b[64]) pend--;
            end
            if (d_valid) begin
                if (rdy && cur_q.size() < WORDS) cur_q.push_back(d_data);
                else m_err = 1'b1;
            end
            if (s_valid) begin
                if (rdy) begin
                    if (cur_q.size() != WORDS) m_err = 1'b1;
                    exp_q.push_back({1'b1, 1'b0, 63'd0, s_flag});
                    for (int k = 0; k < WORDS; k++) begin
                        exp_q.push_back({1'b0, (k == WORDS - 1),
                                         (k < cur_q.size()) ? cur_q[k] : 64'd0});
                    end
                    cur_q.delete();
                    pend++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int seen;
        d_data  = '0;
        d_valid = 1'b0;
        s_flag  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Reset state
        tick();
        chk("reset outputs", {m_valid, m_hdr, m_last, err_o, m_data[61:0]}, 66'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready after reset", 66'(ready_o), 66'd1);
        chk("idle after reset", {m_valid, m_hdr, m_last, err_o, m_data[61:0]}, 66'd0);

        // 1: single block, header two cycles after the close strobe
        m_ready = 1'b1;
        b0 = beats;
        send_block(8, 1'b1);
        chk("t1 no m_valid at s+1", 66'(m_valid), 66'd0);
        tick();
        chk("t1 header at s+2", {m_valid, m_hdr, m_data}, {2'b11, 64'h1});
        wait_last();
        chk("t1 last word", {m_valid, m_last, m_data}, {2'b11, 64'h88});
        wait_drain("t1 drained");
        chk("t1 beat count", 66'(beats - b0), 66'd9);
        chk("t1 err", 66'(err_o), 66'd0);

        // 2: stall for 5 cycles on word 3
        b0 = beats;
        send_block(8, 1'b0);
        for (int i = 0; i < 60 && !(m_valid && !m_hdr && m_data == 64'h44); i++) tick();
        chk("t2 word 3 presented", {m_valid, m_hdr, m_data}, {2'b10, 64'h44});
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2 hold word 3", {m_valid, m_hdr, m_last, m_data}, {3'b100, 64'h44});
            tick();
        end
        m_ready = 1'b1;
        wait_drain("t2 drained");
        chk("t2 beat count", 66'(beats - b0), 66'd9);

        // 3: two blocks back to back with the sink stalled
        m_ready = 1'b0;
        b0 = beats;
        send_block(8, 1'b0);
        send_block(8, 1'b1);
        chk("t3 ready low after 2nd close", 66'(ready_o), 66'd0);
        m_ready = 1'b1;
        wait_last();
        chk("t3 A last, still full", {m_valid, m_last, ready_o}, 66'b110);
        tick();
        chk("t3 bubble, ready back", {m_valid, ready_o}, 66'b01);
        tick();
        chk("t3 B header", {m_valid, m_hdr, m_data}, {2'b11, 64'h1});
        wait_drain("t3 drained");
        chk("t3 beat count", 66'(beats - b0), 66'd18);

        // 5: ninth word overflows and is dropped
        chk("t5 err before", 66'(err_o), 66'd0);
        send_block(9, 1'b1);
        chk("t5 err set", 66'(err_o), 66'd1);
        wait_last();
        chk("t5 last is word 8", {m_valid, m_last, m_data}, {2'b11, 64'h88});
        wait_drain("t5 drained");

        // clear the sticky error
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("err cleared by reset", 66'(err_o), 66'd0);

        // 4: short block, unwritten slots read zero
        send_block(5, 1'b0);
        chk("t4 err set", 66'(err_o), 66'd1);
        wait_last();
        chk("t4 last word zero", {m_valid, m_last, m_data}, {2'b11, 64'h0});
        wait_drain("t4 drained");
        chk("t4 err sticky", 66'(err_o), 66'd1);

        // 6: reset during data beat 4
        send_block(8, 1'b1);
        for (int i = 0; i < 60 && !(m_valid && !m_hdr && m_data == 64'h55); i++) tick();
        chk("t6 beat 4 presented", {m_valid, m_hdr, m_data}, {2'b10, 64'h55});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 outputs cleared", {m_valid, err_o, m_data}, 66'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6 ready after reset", 66'(ready_o), 66'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_valid) seen++;
        end
        chk("t6 no residual frame", 66'(seen), 66'd0);

        chk("scoreboard empty", 66'(exp_q.size()), 66'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
